light_zone_arbiter: RTL and testbench

- Shares a limited lighting power budget among NZ zones.
- Each zone raises a light request, typically the int_light output of that zone's light_control instance.
- Grants at most MAX_ON lit zones at once, admits at most one new zone per cycle to limit inrush current, and holds each grant for a minimum on-time.
- A per-zone manual force bypasses the budget. Sits between the per-zone light_control blocks and the lamp drivers.

---
 rtl/light_pkg.sv | 21 ++
 rtl/zone_hold_timer.sv | 60 ++++++
 rtl/light_zone_arbiter.sv | 74 +++++++
 tb/tb_light_zone_arbiter.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/light_pkg.sv
// Shared types and defaults for the lighting-zone power arbiter.
package light_pkg;

    localparam int NZ_DEF     = 4;
    localparam int MAX_ON_DEF = 2;
    localparam int MIN_ON_DEF = 16;

    typedef enum logic [1:0] {
        ZS_OFF  = 2'd0,
        ZS_HOLD = 2'd1,
        ZS_ON   = 2'd2
    } zone_state_e;

    function automatic logic [3:0] popcount(input logic [7:0] v);
        logic [3:0] c;
        c = '0;
        for (int i = 0; i < 8; i++) c = c + 4'(v[i]);
        return c;
    endfunction

endpackage

// File: rtl/zone_hold_timer.sv
// One lighting zone: OFF/HOLD/ON sequencing with a minimum on-time down-counter.
//   state | meaning
//   OFF   | lamp dark, zone may be granted or forced on
//   HOLD  | lamp lit, minimum on-time running, request ignored
//   ON    | lamp lit, stays lit while req_any holds
module zone_hold_timer
    import light_pkg::*;
#(
    parameter int MIN_ON = MIN_ON_DEF,
    parameter int CW     = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        req_any,
    output zone_state_e state,
    output logic        lit,
    output logic        lit_next
);

    logic [CW-1:0] timer;

    // lit_next lets the top register its lit-zone count alongside lit
    always_comb begin
        lit_next = 1'b0;
        case (state)
            ZS_OFF:  lit_next = load;
            ZS_HOLD: lit_next = (timer != '0) || req_any;
            ZS_ON:   lit_next = req_any;
            default: lit_next = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ZS_OFF;
            timer <= '0;
            lit   <= 1'b0;
        end else begin
            lit <= lit_next;
            case (state)
                ZS_OFF: begin
                    if (load) begin
                        state <= ZS_HOLD;
                        timer <= CW'(MIN_ON - 1);
                    end
                end
                ZS_HOLD: begin
                    if (timer == '0) state <= req_any ? ZS_ON : ZS_OFF;
                    else             timer <= timer - 1'b1;
                end
                ZS_ON: begin
                    if (!req_any) state <= ZS_OFF;
                end
                default: state <= ZS_OFF;
            endcase
        end
    end

endmodule

// File: rtl/light_zone_arbiter.sv
// Shares a lamp power budget among NZ zones: round-robin admission of one zone
// per cycle, at most MAX_ON arbitrated zones lit, manual force bypasses budget.
module light_zone_arbiter
    import light_pkg::*;
#(
    parameter int NZ     = NZ_DEF,
    parameter int MAX_ON = MAX_ON_DEF,
    parameter int MIN_ON = MIN_ON_DEF,
    parameter int CW     = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [NZ-1:0] req,
    input  logic [NZ-1:0] force_on,
    output logic [NZ-1:0] light_en,
    output logic [NZ-1:0] waiting,
    output logic [3:0]    active_cnt
);

    localparam int PW = (NZ > 2) ? $clog2(NZ) : 1;

    logic [PW-1:0] ptr, ptr_nxt;
    logic [NZ-1:0] grant, is_off, lit_next;
    zone_state_e   zs [NZ];
    logic          found;
    int            j;

    // Budget is judged on the registered count, so a slot freed this edge
    // becomes grantable one cycle later.
    always_comb begin
        grant   = '0;
        ptr_nxt = ptr;
        found   = 1'b0;
        j       = 0;
        if (active_cnt < 4'(MAX_ON)) begin
            for (int k = 0; k < NZ; k++) begin
                j = int'(ptr) + k;
                if (j >= NZ) j = j - NZ;
                if (!found && req[j] && !force_on[j] && is_off[j]) begin
                    grant[j] = 1'b1;
                    found    = 1'b1;
                    ptr_nxt  = (j == NZ - 1) ? '0 : PW'(j + 1);
                end
            end
        end
    end

    for (genvar i = 0; i < NZ; i++) begin : g_zone
        assign is_off[i] = (zs[i] == ZS_OFF);

        zone_hold_timer #(.MIN_ON(MIN_ON), .CW(CW)) u_zone (
            .clk      (clk),
            .reset    (reset),
            .load     (grant[i] | (force_on[i] & is_off[i])),
            .req_any  (req[i] | force_on[i]),
            .state    (zs[i]),
            .lit      (light_en[i]),
            .lit_next (lit_next[i])
        );
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr        <= '0;
            active_cnt <= '0;
        end else begin
            ptr        <= ptr_nxt;
            active_cnt <= popcount(8'(lit_next));
        end
    end

    assign waiting = req & ~light_en;

endmodule

// File: tb/tb_light_zone_arbiter.sv
// Randomized bench for light_zone_arbiter against a cycle-level behavioural model.
module tb_light_zone_arbiter;

    localparam int NZ     = 4;
    localparam int MAX_ON = 2;
    localparam int MIN_ON = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [NZ-1:0] req = '0;
    logic [NZ-1:0] force_on = '0;
    logic [NZ-1:0] light_en, waiting;
    logic [3:0]    active_cnt;

    int n_chk  = 0;
    int n_pass = 0;

    // Model: a zone is lit from the edge it is admitted; it may go dark only
    // once MIN_ON edges have passed since admission and neither req nor force.
    bit m_lit   [NZ];
    int m_entry [NZ];
    int m_ptr;
    int m_cyc;

    light_zone_arbiter #(.NZ(NZ), .MAX_ON(MAX_ON), .MIN_ON(MIN_ON), .CW(5)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .force_on   (force_on),
        .light_en   (light_en),
        .waiting    (waiting),
        .active_cnt (active_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        if (obs !== exp)
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        else
            n_pass++;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NZ; i++) begin
            m_lit[i]   = 1'b0;
            m_entry[i] = 0;
        end
        m_ptr = 0;
        m_cyc = 0;
    endtask

    function automatic logic [NZ-1:0] m_vec();
        logic [NZ-1:0] v;
        for (int i = 0; i < NZ; i++) v[i] = m_lit[i];
        return v;
    endfunction

    task automatic model_edge(input logic [NZ-1:0] r, input logic [NZ-1:0] f);
        int cnt = 0;
        int g = -1;
        for (int i = 0; i < NZ; i++) cnt += m_lit[i];
        if (cnt < MAX_ON)
            for (int k = 0; k < NZ; k++) begin
                int z = (m_ptr + k) % NZ;
                if (g < 0 && r[z] && !f[z] && !m_lit[z]) g = z;
            end
        for (int i = 0; i < NZ; i++) begin
            if (!m_lit[i]) begin
                if (i == g || f[i]) begin
                    m_lit[i]   = 1'b1;
                    m_entry[i] = m_cyc;
                end
            end else if (m_cyc - m_entry[i] >= MIN_ON && !r[i] && !f[i]) begin
                m_lit[i] = 1'b0;
            end
        end
        if (g >= 0) m_ptr = (g + 1) % NZ;
        m_cyc++;
    endtask

    task automatic cycle(input logic [NZ-1:0] r, input logic [NZ-1:0] f);
        logic [NZ-1:0] e;
        int c;
        req      = r;
        force_on = f;
        @(posedge clk);
        model_edge(r, f);
        #1;
        e = m_vec();
        c = 0;
        for (int i = 0; i < NZ; i++) c += m_lit[i];
        chk("light_en", 8'(light_en), 8'(e));
        chk("waiting", 8'(waiting), 8'(r & ~e));
        chk("active_cnt", 8'(active_cnt), 8'(c));
    endtask

    initial begin
        logic [NZ-1:0] r, f;

        model_reset();
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("reset_light_en", 8'(light_en), 8'h00);
        chk("reset_cnt", 8'(active_cnt), 8'h00);
        chk("reset_waiting", 8'(waiting), 8'h00);
        cycle('0, '0);

        // Budget and round-robin from pointer 0
        cycle(4'b1111, '0);
        chk("rr_first", 8'(light_en), 8'h01);
        cycle(4'b1111, '0);
        chk("rr_second", 8'(light_en), 8'h03);
        chk("rr_waiting", 8'(waiting), 8'h0C);
        chk("rr_cnt", 8'(active_cnt), 8'd2);
        repeat (3) cycle(4'b1111, '0);
        chk("rr_hold", 8'(light_en), 8'h03);

        // Force beyond budget
        cycle(4'b1111, 4'b1000);
        chk("force_light_en", 8'(light_en), 8'h0B);
        chk("force_cnt", 8'(active_cnt), 8'd3);
        chk("force_waiting", 8'(waiting), 8'h04);

        // Randomized traffic
        r = '0;
        f = '0;
        for (int n = 0; n < 4000; n++) begin
            for (int i = 0; i < NZ; i++) begin
                if ($urandom_range(7) == 0) r[i] = ~r[i];
                if (!f[i] && $urandom_range(40) == 0) f[i] = 1'b1;
                else if (f[i] && $urandom_range(5) == 0) f[i] = 1'b0;
            end
            cycle(r, f);
        end

        // Minimum hold: zone 0 stays lit exactly MIN_ON cycles after a 1-cycle request
        repeat (MIN_ON + 2) cycle('0, '0);
        chk("idle_before_hold", 8'(light_en), 8'h00);
        cycle(4'b0001, '0);
        for (int n = 1; n < MIN_ON; n++) cycle('0, '0);
        chk("hold_last_cycle", 8'(light_en), 8'h01);
        cycle('0, '0);
        chk("hold_released", 8'(light_en), 8'h00);

        // Async reset mid-HOLD
        cycle(4'b0100, '0);
        cycle('0, '0);
        chk("pre_reset_lit", 8'(light_en), 8'h04);
        #2 reset = 1'b0;
        #1;
        chk("async_light_en", 8'(light_en), 8'h00);
        chk("async_cnt", 8'(active_cnt), 8'h00);
        model_reset();
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        repeat (3) cycle('0, '0);
        chk("post_reset_idle", 8'(light_en), 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
